boot_loader: RTL and testbench

- Hardware start-up block between instruction ROM, data RAM and top_core.
- After reset release, copies the initialised-data image from ROM (byte address SRC_BASE upward) into RAM (byte address DST_BASE upward), one 32-bit word per cycle.
- Holds the core in reset during the copy, then releases it and hands the ROM and RAM buses to the core through a registered-select mux.
- Replaces bench-side forcing of RAM and the state machine, so silicon and simulation boot identically.

---
 rtl/boot_loader_pkg.sv | 13 +
 rtl/boot_copy_ctrl.sv | 74 +++++++
 rtl/boot_loader.sv | 52 +++++
 tb/tb_boot_loader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared encodings for the boot loader.
// Holds the RAM write-enable codes and the boot FSM state type.
package boot_loader_pkg;
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b110;
  typedef enum logic [2:0] {
    BOOT_RESET,
    BOOT_PRIME,
    BOOT_COPY,
    BOOT_RELEASE,
    BOOT_RUN
  } boot_state_e;
endpackage

// File: rtl/boot_copy_ctrl.sv
// boot_copy_ctrl: boot FSM, word counter and ROM->RAM copy address generation.
// Ports: clk, rst_n (async active-low); rom_qout (ROM data, one cycle latency);
// copy_rom_addr/copy_ram_addr/copy_ram_qin/copy_ram_we (copy-side bus values);
// core_rst_n, boot_done (registered hand-over flags).
module boot_copy_ctrl
  import boot_loader_pkg::*;
#(
  parameter int AWIDTH     = 14,
  parameter int XLEN       = 32,
  parameter int SRC_BASE   = 'h800,
  parameter int DST_BASE   = 'h000,
  parameter int COPY_BYTES = 2 ** AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   rom_qout,
  output logic [AWIDTH-1:0] copy_rom_addr,
  output logic [AWIDTH-1:0] copy_ram_addr,
  output logic [XLEN-1:0]   copy_ram_qin,
  output logic [2:0]        copy_ram_we,
  output logic              core_rst_n,
  output logic              boot_done
);
  localparam int NWORDS = COPY_BYTES / 4;
  localparam logic [AWIDTH-1:0] SRC  = AWIDTH'(SRC_BASE);
  localparam logic [AWIDTH-1:0] DST  = AWIDTH'(DST_BASE);
  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NWORDS - 1);
  if (COPY_BYTES % 4 != 0) begin : g_bad_size
    $error("boot_copy_ctrl: COPY_BYTES must be a multiple of 4");
  end
  if (SRC_BASE % 4 != 0 || DST_BASE % 4 != 0) begin : g_bad_align
    $error("boot_copy_ctrl: SRC_BASE and DST_BASE must be word-aligned");
  end
  if (DST_BASE + COPY_BYTES > 2 ** AWIDTH) begin : g_bad_range
    $error("boot_copy_ctrl: DST_BASE+COPY_BYTES exceeds the RAM");
  end
  boot_state_e       state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              in_copy;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT_RESET: state_d = BOOT_PRIME;
      BOOT_PRIME: state_d = NWORDS == 0 ? BOOT_RELEASE : BOOT_COPY;
      BOOT_COPY: begin
        cnt_d   = cnt_q + AWIDTH'(1);
        state_d = cnt_q == LAST ? BOOT_RELEASE : BOOT_COPY;
      end
      default: state_d = BOOT_RUN;
    endcase
    done_d = done_q | (state_q == BOOT_RELEASE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT_RESET;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
  // ROM runs one word ahead of the RAM write because its data arrives a cycle late.
  assign in_copy       = state_q == BOOT_COPY;
  assign copy_rom_addr = SRC + ((cnt_q + AWIDTH'(in_copy)) << 2);
  assign copy_ram_addr = DST + (cnt_q << 2);
  assign copy_ram_qin  = in_copy ? rom_qout : '0;
  assign copy_ram_we   = in_copy ? WE_WORD : WE_NONE;
  assign core_rst_n    = done_q;
  assign boot_done     = done_q;
endmodule

// File: rtl/boot_loader.sv
// boot_loader: copies the data image ROM->RAM after reset, then hands both buses to the core.
// Ports: clk, rst_n (async active-low); core_inst_addr/core_inst_data (core fetch);
// rom_addr/rom_qout (ROM); core_dmem_addr/wdata/we (core data side);
// ram_addr/ram_qin/ram_we (RAM); core_rst_n, boot_done (registered).
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int AWIDTH     = 14,
  parameter int XLEN       = 32,
  parameter int SRC_BASE   = 'h800,
  parameter int DST_BASE   = 'h000,
  parameter int COPY_BYTES = 2 ** AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] core_inst_addr,
  output logic [XLEN-1:0]   core_inst_data,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_qout,
  input  logic [AWIDTH-1:0] core_dmem_addr,
  input  logic [XLEN-1:0]   core_dmem_wdata,
  input  logic [2:0]        core_dmem_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]   ram_qin,
  output logic [2:0]        ram_we,
  output logic              core_rst_n,
  output logic              boot_done
);
  logic [AWIDTH-1:0] copy_rom_addr, copy_ram_addr;
  logic [XLEN-1:0]   copy_ram_qin;
  logic [2:0]        copy_ram_we;
  boot_copy_ctrl #(
    .AWIDTH(AWIDTH), .XLEN(XLEN), .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE), .COPY_BYTES(COPY_BYTES)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .rom_qout     (rom_qout),
    .copy_rom_addr(copy_rom_addr),
    .copy_ram_addr(copy_ram_addr),
    .copy_ram_qin (copy_ram_qin),
    .copy_ram_we  (copy_ram_we),
    .core_rst_n   (core_rst_n),
    .boot_done    (boot_done)
  );
  // Select is the registered boot_done, so the FSM next-state never reaches the buses.
  assign core_inst_data = rom_qout;
  assign rom_addr       = boot_done ? core_inst_addr : copy_rom_addr;
  assign ram_addr       = boot_done ? core_dmem_addr : copy_ram_addr;
  assign ram_qin        = boot_done ? core_dmem_wdata : copy_ram_qin;
  assign ram_we         = boot_done ? core_dmem_we : copy_ram_we;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: scoreboard bench for boot_loader with 16-byte, empty and full images.
module tb_boot_loader;
  typedef logic [48:0] wr_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  int wr_a = 0, wr_z = 0, wr_f = 0;
  wr_t q_a[$], q_z[$], q_f[$];
  logic [31:0] ram_a [0:4095];
  logic [31:0] ram_f [0:4095];

  logic        rst_n_a, rst_n_z, rst_n_f;
  logic [13:0] core_inst_addr_a, core_dmem_addr_a, rom_addr_a, ram_addr_a;
  logic [31:0] core_dmem_wdata_a, core_inst_data_a, rom_qout_a, ram_qin_a;
  logic [2:0]  core_dmem_we_a, ram_we_a;
  logic        core_rst_n_a, boot_done_a;
  logic [13:0] core_inst_addr_z, core_dmem_addr_z, rom_addr_z, ram_addr_z;
  logic [31:0] core_dmem_wdata_z, core_inst_data_z, rom_qout_z, ram_qin_z;
  logic [2:0]  core_dmem_we_z, ram_we_z;
  logic        core_rst_n_z, boot_done_z;
  logic [13:0] core_inst_addr_f, core_dmem_addr_f, rom_addr_f, ram_addr_f;
  logic [31:0] core_dmem_wdata_f, core_inst_data_f, rom_qout_f, ram_qin_f;
  logic [2:0]  core_dmem_we_f, ram_we_f;
  logic        core_rst_n_f, boot_done_f;

  boot_loader #(.COPY_BYTES(16)) u_a (
    .clk(clk), .rst_n(rst_n_a), .core_inst_addr(core_inst_addr_a), .core_inst_data(core_inst_data_a),
    .rom_addr(rom_addr_a), .rom_qout(rom_qout_a), .core_dmem_addr(core_dmem_addr_a),
    .core_dmem_wdata(core_dmem_wdata_a), .core_dmem_we(core_dmem_we_a), .ram_addr(ram_addr_a),
    .ram_qin(ram_qin_a), .ram_we(ram_we_a), .core_rst_n(core_rst_n_a), .boot_done(boot_done_a));
  boot_loader #(.COPY_BYTES(0)) u_z (
    .clk(clk), .rst_n(rst_n_z), .core_inst_addr(core_inst_addr_z), .core_inst_data(core_inst_data_z),
    .rom_addr(rom_addr_z), .rom_qout(rom_qout_z), .core_dmem_addr(core_dmem_addr_z),
    .core_dmem_wdata(core_dmem_wdata_z), .core_dmem_we(core_dmem_we_z), .ram_addr(ram_addr_z),
    .ram_qin(ram_qin_z), .ram_we(ram_we_z), .core_rst_n(core_rst_n_z), .boot_done(boot_done_z));
  boot_loader u_f (
    .clk(clk), .rst_n(rst_n_f), .core_inst_addr(core_inst_addr_f), .core_inst_data(core_inst_data_f),
    .rom_addr(rom_addr_f), .rom_qout(rom_qout_f), .core_dmem_addr(core_dmem_addr_f),
    .core_dmem_wdata(core_dmem_wdata_f), .core_dmem_we(core_dmem_we_f), .ram_addr(ram_addr_f),
    .ram_qin(ram_qin_f), .ram_we(ram_we_f), .core_rst_n(core_rst_n_f), .boot_done(boot_done_f));

  // ROM image: the four test words at 0x800..0x80C, a distinct pattern everywhere else.
  function automatic logic [31:0] rom_val(input logic [13:0] a);
    if (a >= 14'h800 && a <= 14'h80C) return 32'h11111111 * 32'((a - 14'h800) / 4 + 1);
    return {a, 2'b01, ~a, 2'b10} ^ 32'h5A5AC3C3;
  endfunction

  always @(posedge clk) begin
    rom_qout_a <= rom_val(rom_addr_a);
    rom_qout_z <= rom_val(rom_addr_z);
    rom_qout_f <= rom_val(rom_addr_f);
    if (ram_we_a == 3'b110) ram_a[ram_addr_a[13:2]] <= ram_qin_a;
    if (ram_we_f == 3'b110) ram_f[ram_addr_f[13:2]] <= ram_qin_f;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every RAM write pops the next expected {we,addr,data}.
  always @(negedge clk) if (ram_we_a !== 3'b000) begin
    wr_a++;
    if (q_a.size() == 0) check("a_spurious_write", {ram_we_a, ram_addr_a, ram_qin_a}, 0);
    else check("a_write", {ram_we_a, ram_addr_a, ram_qin_a}, q_a.pop_front());
  end
  always @(negedge clk) if (ram_we_z !== 3'b000) begin
    wr_z++;
    if (q_z.size() == 0) check("z_spurious_write", {ram_we_z, ram_addr_z, ram_qin_z}, 0);
    else check("z_write", {ram_we_z, ram_addr_z, ram_qin_z}, q_z.pop_front());
  end
  always @(negedge clk) if (ram_we_f !== 3'b000) begin
    wr_f++;
    if (q_f.size() == 0) check("f_spurious_write", {ram_we_f, ram_addr_f, ram_qin_f}, 0);
    else check("f_write", {ram_we_f, ram_addr_f, ram_qin_f}, q_f.pop_front());
  end

  function automatic logic crst(input int w);
    return w == 0 ? core_rst_n_a : w == 1 ? core_rst_n_z : core_rst_n_f;
  endfunction

  // Called right after rst_n rises; counts edges after the first active one until core_rst_n.
  task automatic run_boot(input string name, input int w, input int exp_lat, input int bound);
    int n = 0;
    @(posedge clk);
    #1;
    while (!crst(w) && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, exp_lat);
  endtask

  task automatic push_a4();
    for (int i = 0; i < 4; i++) q_a.push_back({3'b110, 14'(4 * i), 32'h11111111 * 32'(i + 1)});
  endtask

  initial begin
    int n;
    int bad;
    for (int i = 0; i < 4096; i++) begin
      ram_a[i] = '0;
      ram_f[i] = '0;
    end
    rst_n_a = 0; rst_n_z = 0; rst_n_f = 0;
    core_inst_addr_a = 14'h3FC; core_dmem_addr_a = 14'h200;
    core_dmem_wdata_a = 32'h0BADF00D; core_dmem_we_a = 3'b110;
    core_inst_addr_z = '0; core_dmem_addr_z = '0; core_dmem_wdata_z = '0; core_dmem_we_z = '0;
    core_inst_addr_f = '0; core_dmem_addr_f = '0; core_dmem_wdata_f = '0; core_dmem_we_f = '0;
    repeat (3) @(negedge clk);
    check("rst_ram_we", ram_we_a, 3'b000);
    check("rst_core_rst_n", core_rst_n_a, 0);
    check("rst_boot_done", boot_done_a, 0);
    check("rst_rom_addr", rom_addr_a, 14'h800);
    check("rst_ram_addr", ram_addr_a, 14'h000);
    check("rst_ram_qin", ram_qin_a, 0);
    push_a4();
    rst_n_a = 1;
    n = 0;
    while (wr_a < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_two_writes", wr_a, 2);
    rst_n_a = 0;
    #1;
    check("abort_ram_we", ram_we_a, 3'b000);
    check("abort_core_rst_n", core_rst_n_a, 0);
    check("abort_ram_addr", ram_addr_a, 14'h000);
    check("abort_rom_addr", rom_addr_a, 14'h800);
    q_a.delete();
    wr_a = 0;
    repeat (2) @(negedge clk);
    push_a4();
    rst_n_a = 1;
    run_boot("a_latency", 0, 6, 40);
    check("a_boot_done", boot_done_a, 1);
    check("a_write_count", wr_a, 4);
    check("a_queue_empty", q_a.size(), 0);
    q_a.push_back({3'b110, 14'h100, 32'hDEADBEEF});
    core_inst_addr_a = 14'h004; core_dmem_addr_a = 14'h100;
    core_dmem_wdata_a = 32'hDEADBEEF; core_dmem_we_a = 3'b110;
    #1;
    check("run_rom_addr", rom_addr_a, 14'h004);
    check("run_ram_addr", ram_addr_a, 14'h100);
    @(posedge clk);
    #1;
    core_dmem_we_a = 3'b000;
    @(negedge clk);
    check("run_inst_data", core_inst_data_a, rom_qout_a);
    check("run_queue_empty", q_a.size(), 0);
    check("ram_100", ram_a[14'h100 >> 2], 32'hDEADBEEF);
    check("ram_200_untouched", ram_a[14'h200 >> 2], 0);
    for (int i = 0; i < 4; i++) check("ram_image", ram_a[i], 32'h11111111 * 32'(i + 1));
    rst_n_a = 0;
    #1;
    check("run_reset_core_rst_n", core_rst_n_a, 0);
    check("run_reset_boot_done", boot_done_a, 0);
    @(negedge clk);
    rst_n_z = 1;
    run_boot("z_latency", 1, 2, 20);
    check("z_boot_done", boot_done_z, 1);
    repeat (3) @(negedge clk);
    check("z_no_writes", wr_z, 0);
    for (int i = 0; i < 4096; i++) q_f.push_back({3'b110, 14'(4 * i), rom_val(14'(32'h800 + 4 * i))});
    rst_n_f = 1;
    run_boot("f_latency", 2, 4098, 5000);
    repeat (4) @(negedge clk);
    check("f_write_count", wr_f, 4096);
    check("f_queue_empty", q_f.size(), 0);
    bad = 0;
    for (int i = 0; i < 4096; i++) if (ram_f[i] !== rom_val(14'(32'h800 + 4 * i))) bad++;
    check("f_ram_image", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
